move_arbiter: RTL

- Shares the single frog-position update path between N player/debug move requesters.
- Each raw button level is synchronized and edge-detected, then latched as a pending request.
- Pending requests are served round-robin as one-cycle grant pulses, with a cooldown between grants that rate-limits moves.
- Sits between the board key inputs and the frog position registers; the gnt pulse is the write enable for exactly one move.

---
 rtl/move_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/move_arbiter.sv
// Round-robin arbiter that turns N raw button levels into rate-limited one-cycle move grants.
// Build with AUTO_REPEAT_EN defined to make a held key re-request every REPEAT cycles.
module move_arbiter #(
  parameter int N        = 4,
  parameter int COOLDOWN = 8,
  parameter int REPEAT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 enable,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic [N-1:0]         pending
);
  localparam int W  = $clog2(N);
  localparam int CW = $clog2(COOLDOWN + 1);

  typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    s1_q, s1_d, s2_q, s2_d, prv_q, prv_d;
  logic [N-1:0]    pending_q, pending_d, gnt_q, gnt_d;
  logic [W-1:0]    gnt_id_q, gnt_id_d, ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    rise, rpt_set, clr;
  logic            found;
  logic [W-1:0]    win;

  assign rise = s2_q & ~prv_q;

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT);
  logic [N-1:0][RW-1:0] rcnt_q, rcnt_d;

  always_comb begin
    rcnt_d  = rcnt_q;
    rpt_set = '0;
    for (int i = 0; i < N; i++) begin
      if (rise[i] || !s2_q[i]) begin
        rcnt_d[i] = '0;
      end else if (rcnt_q[i] == RW'(REPEAT - 1)) begin
        rcnt_d[i]  = '0;
        rpt_set[i] = 1'b1;
      end else begin
        rcnt_d[i] = rcnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end
`else
  assign rpt_set = '0;
`endif

  // First pending bit at or above ptr, wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int j = 0; j < N; j++) begin
      idx = (int'(ptr_q) + j) % N;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        win   = W'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    clr      = '0;
    s1_d     = req;
    s2_d     = s1_q;
    prv_d    = s2_q;
    case (state_q)
      IDLE: if (enable && found) begin
        gnt_d[win] = 1'b1;
        gnt_id_d   = win;
        clr[win]   = 1'b1;
        ptr_d      = (win == W'(N - 1)) ? '0 : win + 1'b1;
        state_d    = GRANT;
      end
      GRANT: begin
        cnt_d   = CW'(COOLDOWN - 1);
        state_d = COOL;
      end
      COOL: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    // A new request landing on the bit being granted must survive.
    pending_d = (pending_q & ~clr) | rise | rpt_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      prv_q     <= '0;
      pending_q <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      prv_q     <= prv_d;
      pending_q <= pending_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign pending = pending_q;
endmodule
